// File: rtl/bus_dev_endpoint.sv
// ---------------------------------------------------------------------------
// bus_dev_endpoint
//   Device-side endpoint of the bs_gnrtr_n_rbtr bus. This block holds two
//   FIFOs. The TX FIFO is loaded by the host and drained by the bus. The RX
//   FIFO captures bus pushes addressed to this device, or to the broadcast
//   ID, and is drained by the host.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   wr_en, wr_data       host write into TX FIFO
//   tx_full, tx_count    TX FIFO status
//   pndng, D_pop, pop    bus side of TX FIFO (D_pop is first-word fall-through)
//   push, D_push         bus delivery into RX FIFO (filtered by destination ID)
//   rd_en, rx_data       host read of RX FIFO (rx_data is first-word fall-through)
//   rx_valid, rx_count   RX FIFO status
//   tx_ovf_cnt           saturating count of TX writes rejected while full
//   rx_drop_cnt          saturating count of matching pushes dropped while full
//   pop_err              sticky flag: pop seen while TX empty
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// bus_dev_fifo
//   Circular-buffer FIFO with a read pointer, a write pointer and an
//   occupancy count. A write is accepted when the FIFO is not full, or when a
//   read retires an entry in the same cycle. rd_data shows the head entry
//   combinationally and is 0 while the FIFO is empty. The reject output
//   pulses when a write is refused.
// ---------------------------------------------------------------------------
module bus_dev_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd,
  output logic [width-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(depth):0]   count,
  output logic                     reject
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_lvl = (aw+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    rd_ptr, wr_ptr;
  logic             do_wr, do_rd;

  // Status flags depend only on the count register, so they carry no
  // combinational path from the inputs.
  assign valid  = (count != '0);
  assign full   = (count == full_lvl);
  assign do_rd  = rd && valid;
  assign do_wr  = wr && (!full || do_rd);
  assign reject = wr && !do_wr;

  assign rd_data = valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array has no reset. Clearing the pointers and the count
  // empties the FIFO, and rd_data is masked while the FIFO is empty, so stale
  // contents are never observable.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all state registers use non-blocking assignments, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // depth is a power of two, so the pointers wrap naturally
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module bus_dev_endpoint #(
  parameter int              pckg_sz   = 16,
  parameter int              depth     = 8,
  parameter int              id_w      = 8,
  parameter logic [id_w-1:0] dev_id    = '0,
  parameter logic [id_w-1:0] broadcast = '1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [pckg_sz-1:0]        wr_data,
  output logic                      tx_full,
  output logic [$clog2(depth):0]    tx_count,
  output logic                      pndng,
  output logic [pckg_sz-1:0]        D_pop,
  input  logic                      pop,
  input  logic                      push,
  input  logic [pckg_sz-1:0]        D_push,
  input  logic                      rd_en,
  output logic [pckg_sz-1:0]        rx_data,
  output logic                      rx_valid,
  output logic [$clog2(depth):0]    rx_count,
  output logic [7:0]                tx_ovf_cnt,
  output logic [7:0]                rx_drop_cnt,
  output logic                      pop_err
);
  logic [id_w-1:0] dest;
  logic            rx_accept;
  logic            tx_reject, rx_reject;

  // The destination ID is the top id_w bits of the packet.
  assign dest      = D_push[pckg_sz-1 -: id_w];
  assign rx_accept = push && ((dest == dev_id) || (dest == broadcast));

  bus_dev_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr_en),
    .wr_data (wr_data),
    .rd      (pop),
    .rd_data (D_pop),
    .valid   (pndng),
    .full    (tx_full),
    .count   (tx_count),
    .reject  (tx_reject)
  );

  bus_dev_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_accept),
    .wr_data (D_push),
    .rd      (rd_en),
    .rd_data (rx_data),
    .valid   (rx_valid),
    .full    (),
    .count   (rx_count),
    .reject  (rx_reject)
  );

  // The error counters saturate at 8'hFF instead of wrapping. pop_err stays
  // set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_cnt  <= '0;
      rx_drop_cnt <= '0;
      pop_err     <= 1'b0;
    end else begin
      if (tx_reject && (tx_ovf_cnt != 8'hFF))  tx_ovf_cnt  <= tx_ovf_cnt + 8'd1;
      if (rx_reject && (rx_drop_cnt != 8'hFF)) rx_drop_cnt <= rx_drop_cnt + 8'd1;
      if (pop && !pndng)                       pop_err     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// ---------------------------------------------------------------------------
// tb_bus_dev_endpoint
//   Directed bench for bus_dev_endpoint with dev_id = 2. Inputs change 1 ns
//   after each rising edge, and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_bus_dev_endpoint;
  logic        clk = 1'b0;
  logic        reset, wr_en, pop, push, rd_en;
  logic [15:0] wr_data, D_push, D_pop, rx_data;
  logic        tx_full, pndng, rx_valid, pop_err;
  logic [3:0]  tx_count, rx_count;
  logic [7:0]  tx_ovf_cnt, rx_drop_cnt;
  int          checks = 0;
  int          errors = 0;

  bus_dev_endpoint #(.pckg_sz(16), .depth(8), .id_w(8), .dev_id(8'd2), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .rd_en(rd_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_count(rx_count), .tx_ovf_cnt(tx_ovf_cnt), .rx_drop_cnt(rx_drop_cnt), .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; pop = 0; push = 0; rd_en = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({pndng, rx_valid, tx_full, pop_err} !== 4'b0) begin
      errors++; $display("FAIL %s_flags got %b exp 0000", tag, {pndng, rx_valid, tx_full, pop_err});
    end
    checks++;
    if ({tx_count, rx_count} !== 8'h00) begin
      errors++; $display("FAIL %s_counts got tx=%0d rx=%0d exp 0 0", tag, tx_count, rx_count);
    end
    checks++;
    if ({tx_ovf_cnt, rx_drop_cnt} !== 16'h0) begin
      errors++; $display("FAIL %s_errcnt got ovf=%0d drop=%0d exp 0 0", tag, tx_ovf_cnt, rx_drop_cnt);
    end
    checks++;
    if ({D_pop, rx_data} !== 32'h0) begin
      errors++; $display("FAIL %s_data got D_pop=%h rx_data=%h exp 0 0", tag, D_pop, rx_data);
    end
  endtask

  task automatic test_reset();
    idle(); wr_data = '0; D_push = '0;
    reset = 1;
    repeat (5) step();
    reset = 0;
    step();
    check_all_zero("reset");
  endtask

  task automatic test_tx();
    wr_en = 1; wr_data = 16'h0311; step();
    wr_data = 16'h0122; step();
    wr_en = 0; step();
    checks++;
    if (pndng !== 1'b1 || D_pop !== 16'h0311) begin
      errors++; $display("FAIL tx_first got pndng=%b D_pop=%h exp 1 0311", pndng, D_pop);
    end
    checks++;
    if (tx_count !== 4'd2) begin errors++; $display("FAIL tx_count2 got %0d exp 2", tx_count); end
    pop = 1; step(); pop = 0;
    checks++;
    if (D_pop !== 16'h0122 || tx_count !== 4'd1) begin
      errors++; $display("FAIL tx_pop1 got D_pop=%h cnt=%0d exp 0122 1", D_pop, tx_count);
    end
    pop = 1; step(); pop = 0;
    checks++;
    if (pndng !== 1'b0 || tx_count !== 4'd0 || D_pop !== 16'h0) begin
      errors++; $display("FAIL tx_pop2 got pndng=%b cnt=%0d D_pop=%h exp 0 0 0", pndng, tx_count, D_pop);
    end
    checks++;
    if (pop_err !== 1'b0) begin errors++; $display("FAIL tx_pop_err got %b exp 0", pop_err); end
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1; wr_data = 16'h1000 + 16'(i); step();
      if (i == 6) begin
        checks++;
        if (tx_full !== 1'b0) begin errors++; $display("FAIL tx_full7 got %b exp 0", tx_full); end
      end
      if (i == 7) begin
        checks++;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL tx_full8 got %b exp 1", tx_full); end
      end
    end
    wr_en = 0;
    checks++;
    if (tx_ovf_cnt !== 8'd1 || tx_count !== 4'd8 || D_pop !== 16'h1000) begin
      errors++; $display("FAIL tx_ovf got ovf=%0d cnt=%0d D_pop=%h exp 1 8 1000", tx_ovf_cnt, tx_count, D_pop);
    end
    // A write and a pop in the same cycle while full: the pop frees a slot.
    wr_en = 1; pop = 1; wr_data = 16'h2000; step(); idle();
    checks++;
    if (tx_count !== 4'd8 || D_pop !== 16'h1001 || tx_ovf_cnt !== 8'd1 || tx_full !== 1'b1) begin
      errors++; $display("FAIL tx_full_wrpop got cnt=%0d D_pop=%h ovf=%0d full=%b exp 8 1001 1 1",
                         tx_count, D_pop, tx_ovf_cnt, tx_full);
    end
    // A write and a pop in the same cycle while partly full: the count is unchanged.
    pop = 1; step(); pop = 0;
    wr_en = 1; pop = 1; wr_data = 16'h2001; step(); idle();
    checks++;
    if (tx_count !== 4'd7 || D_pop !== 16'h1003) begin
      errors++; $display("FAIL tx_mid_wrpop got cnt=%0d D_pop=%h exp 7 1003", tx_count, D_pop);
    end
    for (int i = 0; i < 7; i++) begin
      logic [15:0] exp;
      exp = (i < 5) ? 16'h1003 + 16'(i) : 16'h2000 + 16'(i - 5);
      checks++;
      if (D_pop !== exp) begin errors++; $display("FAIL tx_drain%0d got %h exp %h", i, D_pop, exp); end
      pop = 1; step(); pop = 0;
    end
    checks++;
    if (pndng !== 1'b0 || tx_count !== 4'd0 || pop_err !== 1'b0) begin
      errors++; $display("FAIL tx_drained got pndng=%b cnt=%0d err=%b exp 0 0 0", pndng, tx_count, pop_err);
    end
  endtask

  task automatic test_rx_filter();
    push = 1; D_push = 16'h02AA; step();
    D_push = 16'h03BB; step();
    D_push = 16'hFFCC; step();
    push = 0;
    checks++;
    if (rx_count !== 4'd2 || rx_valid !== 1'b1 || rx_data !== 16'h02AA) begin
      errors++; $display("FAIL rx_filter got cnt=%0d valid=%b data=%h exp 2 1 02AA", rx_count, rx_valid, rx_data);
    end
    rd_en = 1; step(); rd_en = 0;
    checks++;
    if (rx_data !== 16'hFFCC || rx_count !== 4'd1) begin
      errors++; $display("FAIL rx_read1 got data=%h cnt=%0d exp FFCC 1", rx_data, rx_count);
    end
    rd_en = 1; step();
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 16'h0) begin
      errors++; $display("FAIL rx_read2 got valid=%b data=%h exp 0 0", rx_valid, rx_data);
    end
    step(); rd_en = 0;
    checks++;
    if (rx_count !== 4'd0 || rx_drop_cnt !== 8'd0) begin
      errors++; $display("FAIL rx_rd_empty got cnt=%0d drop=%0d exp 0 0", rx_count, rx_drop_cnt);
    end
  endtask

  task automatic test_rx_drop();
    push = 1;
    for (int i = 0; i < 8; i++) begin D_push = 16'h0200 + 16'(i); step(); end
    checks++;
    if (rx_count !== 4'd8 || rx_drop_cnt !== 8'd0) begin
      errors++; $display("FAIL rx_fill got cnt=%0d drop=%0d exp 8 0", rx_count, rx_drop_cnt);
    end
    for (int i = 0; i < 300; i++) begin D_push = 16'hFF00 + 16'(i % 256); step(); end
    push = 0;
    checks++;
    if (rx_count !== 4'd8 || rx_drop_cnt !== 8'd255 || rx_data !== 16'h0200) begin
      errors++; $display("FAIL rx_sat got cnt=%0d drop=%0d data=%h exp 8 255 0200", rx_count, rx_drop_cnt, rx_data);
    end
    // An accept and a read in the same cycle while full: the read frees a slot.
    push = 1; rd_en = 1; D_push = 16'h02EE; step(); idle();
    checks++;
    if (rx_count !== 4'd8 || rx_data !== 16'h0201 || rx_drop_cnt !== 8'd255) begin
      errors++; $display("FAIL rx_full_rdacc got cnt=%0d data=%h drop=%0d exp 8 0201 255", rx_count, rx_data, rx_drop_cnt);
    end
    // Put packets in TX as well, then reset while other requests are active.
    wr_en = 1; wr_data = 16'h4444; step();
    reset = 1; push = 1; D_push = 16'h0255; pop = 1; rd_en = 1; step();
    reset = 0; idle(); step();
    check_all_zero("rx_reset");
  endtask

  task automatic test_pop_empty();
    pop = 1; step(); pop = 0;
    checks++;
    if (pop_err !== 1'b1 || tx_count !== 4'd0 || pndng !== 1'b0) begin
      errors++; $display("FAIL pop_empty got err=%b cnt=%0d pndng=%b exp 1 0 0", pop_err, tx_count, pndng);
    end
    // A write and a pop in the same cycle while empty: only the write happens.
    wr_en = 1; pop = 1; wr_data = 16'h5A5A; step(); idle();
    checks++;
    if (tx_count !== 4'd1 || D_pop !== 16'h5A5A || pop_err !== 1'b1) begin
      errors++; $display("FAIL pop_empty_wr got cnt=%0d D_pop=%h err=%b exp 1 5A5A 1", tx_count, D_pop, pop_err);
    end
    pop = 1; step(); pop = 0;
    checks++;
    if (tx_count !== 4'd0 || pop_err !== 1'b1) begin
      errors++; $display("FAIL pop_err_sticky got cnt=%0d err=%b exp 0 1", tx_count, pop_err);
    end
    reset = 1; step(); reset = 0;
    checks++;
    if (pop_err !== 1'b0) begin errors++; $display("FAIL pop_err_reset got %b exp 0", pop_err); end
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_tx();
    test_tx_full();
    test_rx_filter();
    test_rx_drop();
    test_pop_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
